// File: rtl/branch_pkg.sv
// Shared definitions for the sliced branch comparator: RV32I branch funct3 codes,
// FSM state encoding and the funct3-to-result mapping.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCmp  = 2'b01,
    StDone = 2'b10
  } state_e;

  // 010/011 are not branch encodings.
  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic is_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic br_eval(input logic [2:0] f3, input logic eq, input logic lt);
    logic res;
    case (f3)
      F3_BEQ:           res = eq;
      F3_BNE:           res = ~eq;
      F3_BLT, F3_BLTU:  res = lt;
      F3_BGE, F3_BGEU:  res = ~lt;
      default:          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slice_cmp.sv
// Combinational SLICE-wide comparator; sign_fix flips both top bits so an unsigned
// compare orders two's-complement values correctly.
module slice_cmp #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             sign_fix,
  output logic             eq,
  output logic             lt
);

  logic [SLICE-1:0] a_fix;
  logic [SLICE-1:0] b_fix;

  always_comb begin
    a_fix = a;
    b_fix = b;
    if (sign_fix) begin
      a_fix[SLICE-1] = ~a[SLICE-1];
      b_fix[SLICE-1] = ~b[SLICE-1];
    end
    eq = (a == b);
    lt = (a_fix < b_fix);
  end

endmodule

// File: rtl/branch_comp_seq.sv
// Multi-cycle RV32I branch comparator: walks the operands MSB slice first under a
// start/done handshake and resolves BEQ/BNE/BLT/BGE/BLTU/BGEU with fixed latency.
module branch_comp_seq
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  output logic            busy,
  output logic            done,
  output logic            br_res,
  output logic            illegal
);

  localparam int unsigned N    = XLEN / SLICE;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  state_e          state_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [2:0]      f3_q;
  logic [IdxW-1:0] idx_q;
  logic            eq_q, lt_q, decided_q;
  logic            br_res_q, illegal_q;

  logic [SLICE-1:0] a_sl, b_sl;
  logic             sign_fix;
  logic             sl_eq, sl_lt;
  logic             eq_d, lt_d, decided_d;

  always_comb begin
    a_sl     = a_q[idx_q*SLICE +: SLICE];
    b_sl     = b_q[idx_q*SLICE +: SLICE];
    sign_fix = is_signed(f3_q) && (idx_q == IdxTop);
  end

  slice_cmp #(
    .SLICE (SLICE)
  ) u_slice_cmp (
    .a        (a_sl),
    .b        (b_sl),
    .sign_fix (sign_fix),
    .eq       (sl_eq),
    .lt       (sl_lt)
  );

  // The first mismatching slice (from the top) fixes the ordering; later ones are ignored.
  always_comb begin
    eq_d      = eq_q;
    lt_d      = lt_q;
    decided_d = decided_q;
    if (!decided_q && !sl_eq) begin
      decided_d = 1'b1;
      lt_d      = sl_lt;
      eq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      idx_q     <= '0;
      eq_q      <= 1'b1;
      lt_q      <= 1'b0;
      decided_q <= 1'b0;
      br_res_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q       <= rd1;
            b_q       <= rd2;
            f3_q      <= funct3;
            idx_q     <= IdxTop;
            eq_q      <= 1'b1;
            lt_q      <= 1'b0;
            decided_q <= 1'b0;
            state_q   <= StCmp;
          end else begin
            state_q   <= StIdle;
          end
        end
        StCmp: begin
          eq_q      <= eq_d;
          lt_q      <= lt_d;
          decided_q <= decided_d;
          if (idx_q == '0) begin
            br_res_q  <= br_eval(f3_q, eq_d, lt_d);
            illegal_q <= is_illegal(f3_q);
            state_q   <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StCmp);
  assign done    = (state_q == StDone);
  assign br_res  = br_res_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_branch_comp_seq.sv
// Self-checking bench for branch_comp_seq: directed cases plus randomized operations
// checked against a plain-arithmetic model of the RV32I branch conditions.
module tb_branch_comp_seq;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic        busy, done, br_res, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_comp_seq #(
    .XLEN  (XLEN),
    .SLICE (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .funct3  (funct3),
    .rd1     (rd1),
    .rd2     (rd2),
    .busy    (busy),
    .done    (done),
    .br_res  (br_res),
    .illegal (illegal)
  );

  function automatic logic model_res(input logic [2:0] f3, input logic [31:0] a, b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_ill(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // mode 0: quiet; 1: zero operands after acceptance; 2: random operand/start noise.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, b, input int mode);
    int cyc;
    int bcnt;
    logic exp_res;
    exp_res = model_res(f3, a, b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; rd1 = a; rd2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (mode == 1) begin rd1 = '0; rd2 = '0; end
      if (mode == 2) begin
        rd1 = $urandom; rd2 = $urandom; funct3 = 3'($urandom);
        start = (cyc < LAT - 1) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, LAT);
    chk("busy_cycles", bcnt, LAT - 1);
    chk("busy_at_done", busy, 0);
    chk("br_res", br_res, exp_res);
    chk("illegal", illegal, model_ill(f3));
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("br_res_hold", br_res, exp_res);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          m;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_br_res", br_res, 0);
    chk("rst_illegal", illegal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b000, 32'hFFBBCCAA, 32'hFFBBCCAA, 0);
    do_op(3'b001, 32'hFFBBCCAA, 32'hFFBBCCAA, 0);
    do_op(3'b110, 32'hFFBBCCAA, 32'hFFFFFFFF, 0);
    do_op(3'b111, 32'hFFBBCCAA, 32'hFFFFFFFF, 0);
    do_op(3'b000, 32'hFFBBCCAA, 32'hFFFFFFFF, 0);
    do_op(3'b100, 32'hFFBBCCAA, 32'hFFFFFFFF, 0);
    do_op(3'b100, 32'h80000000, 32'h00000001, 0);
    do_op(3'b110, 32'h80000000, 32'h00000001, 0);
    do_op(3'b101, 32'h80000000, 32'h00000001, 0);
    do_op(3'b111, 32'h80000000, 32'h00000001, 0);
    do_op(3'b101, 32'hF7A99BC4, 32'hF7A99BC4, 0);
    do_op(3'b100, 32'hF7A99BC4, 32'hF7A99BC4, 0);
    do_op(3'b110, 32'h12345600, 32'h123456FF, 1);
    do_op(3'b111, 32'h123456FF, 32'h12345600, 2);
    do_op(3'b010, 32'h00000005, 32'h00000005, 0);
    do_op(3'b011, 32'h00000001, 32'h00000002, 2);

    // start held high: a result every LAT cycles
    @(negedge clk);
    start = 1'b1; funct3 = 3'b110; rd1 = 32'd1; rd2 = 32'd2;
    @(posedge clk);
    for (int k = 1; k <= 3 * LAT; k++) begin
      #1;
      chk("b2b_done", done, (k % LAT) == 0);
      if (done) chk("b2b_br_res", br_res, 1);
      if (k < 3 * LAT) @(posedge clk);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_done", done, 0);
    chk("b2b_end_busy", busy, 0);

    // reset during the third CMP cycle, with br_res previously high
    do_op(3'b000, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; rd1 = 32'd7; rd2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_br_res", br_res, 0);
    chk("mid_rst_illegal", illegal, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 1) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", done, 0);
    end
    do_op(3'b000, 32'h0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = {a[31:8], 8'($urandom)};
        2:       b = a ^ 32'h80000000;
        default: b = $urandom;
      endcase
      m = $urandom_range(0, 2);
      do_op(f3, a, b, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_comp_seq.md
# branch_comp_seq

Parametrised, multi-cycle branch comparator, successor to the single-cycle equality comparator. Resolves all six RV32I conditional-branch conditions (BEQ, BNE, BLT, BGE, BLTU, BGEU) from the two register-file read ports. Compares operands SLICE bits at a time, MSB slice first, under a start/done handshake, so wide XLEN configurations never put a full-width magnitude comparator on a single-cycle path. Sits between register-file read and the PC-select logic in the execute stage.

## Interface

- XLEN, 32, operand width; must be a multiple of SLICE.
- SLICE, 8, bits compared per cycle; N = XLEN/SLICE compare cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: asynchronous, active-low; one clock, no other clock domains.
- start  in  1  request; sampled only in IDLE or DONE.
- funct3  in  3  branch type, RISC-V encoding; latched on accepted start.
- rd1  in  XLEN  operand rs1; latched on accepted start.
- rd2  in  XLEN  operand rs2; latched on accepted start.
- busy  out  1  high while in CMP.
- done  out  1  one-cycle pulse; br_res/illegal valid this cycle.
- br_res  out  1  branch taken; held from done until next done.
- illegal  out  1  funct3 was 010 or 011; held like br_res.

## Operation

- States: IDLE, CMP, DONE.
- IDLE: start=1 → latch rd1, rd2, funct3; clear eq_acc=1, lt_acc=0, decided=0; slice index = N-1; go CMP. start=0 → stay.
- CMP: per cycle, compare slice[idx] of both operands.
  - While decided=0: on slice mismatch set decided=1, lt_acc = (a_slice < b_slice) unsigned, eq_acc=0. Once decided=1, later slices are ignored.
  - Signed modes (BLT/BGE): in the MSB slice only, invert the top bit of both slices before the unsigned compare.
  - idx=0 → go DONE; else idx−1.
  - Fixed latency: no early exit on decision.
- DONE: done=1; register br_res/illegal. start=1 is accepted here exactly as in IDLE (back-to-back). Otherwise go IDLE.
- Result per funct3:
  - 000: eq.
  - 001: !eq.
  - 100 and 110: lt.
  - 101 and 111: !lt.
  - 010/011: br_res=0, illegal=1; the full latency still runs.
- start while busy is ignored; no queueing. Operand changes after acceptance have no effect.

## Timing

- Reset (asynchronous assert): state=IDLE; busy=0, done=0, br_res=0, illegal=0; internal accumulators cleared.
- Reset mid-CMP: operation aborted; no done pulse.
- Release: synchronous to clk.
- Latency: start high in cycle c → busy in cycles c+1..c+N → done in cycle c+N+1. Default configuration: done 5 cycles after start.
- Throughput: one result per N+1 cycles with start held or re-asserted in DONE.
- br_res and illegal are registered and change only on the clk edge that enters DONE.

## Structure

- Package branch_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - State encoding for IDLE/CMP/DONE.
- Sub-module slice_cmp: combinational, SLICE-wide. Inputs a, b, sign_fix. Outputs eq and lt (unsigned, after the sign_fix top-bit inversion). Instantiated once, muxed by idx.
- Top level holds the FSM, operand registers, idx counter ($clog2(N) bits), and accumulators.

## Test plan

- BEQ equal: rd1=rd2=FFBBCCAA, funct3=000 → done in cycle c+5, br_res=1, illegal=0; busy high exactly 4 cycles. Repeat with funct3=001 → br_res=0.
- Unsigned vs signed: rd1=FFBBCCAA, rd2=FFFFFFFF.
  - BLTU → 1; BGEU → 0; BEQ → 0.
  - BLT → 1, since −4469590 < −1.
- Signed boundary: rd1=80000000, rd2=00000001 → BLT=1, BLTU=0, BGE=0, BGEU=1. Equal operands F7A99BC4/F7A99BC4 → BGE=1, BLT=0.
- LSB-slice decision: rd1=12345600, rd2=123456FF.
  - BLTU=1; the decision lands only in the last CMP cycle.
  - Driving rd1/rd2 to 0 after acceptance leaves the result unchanged.
- Handshake:
  - funct3=010 → illegal=1, br_res=0 at c+5.
  - start pulses during busy are ignored (exactly one done).
  - start held high → done pulses every 5 cycles.
  - br_res holds between dones.
- Reset: assert rst_n=0 during the third CMP cycle → all outputs 0 immediately, no done. After release, a new BEQ on 0/0 → br_res=1.
